// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its helpers.
package instr_fetch_pkg;

   localparam int unsigned INST_W     = 32;
   localparam int unsigned MEM_ADDR_W = 15;
   localparam int unsigned CNT_W      = 8;
   localparam logic [INST_W-1:0] NOP  = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_RELEASE = 2'd2,
      ST_FAULT   = 2'd3
   } fetch_state_e;

   function automatic logic is_word_aligned(input logic [INST_W-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for signals arriving from another timing domain.
module sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the level-handshake instruction RAM and feeds
// decode through a one-entry valid/ready buffer, with redirect and fault handling.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic                  mem_data_valid,
   output logic [INST_W-1:0]     mem_wdata,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   input  logic                  mem_ready,
   input  logic [INST_W-1:0]     mem_rdata,
   input  logic                  redirect_valid,
   input  logic [INST_W-1:0]     redirect_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [INST_W-1:0]     inst,
   output logic [INST_W-1:0]     inst_pc,
   output logic                  fault
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   fetch_state_e          state_q, state_d;
   logic [INST_W-1:0]     fetch_pc_q, fetch_pc_d;
   logic [INST_W-1:0]     inst_q, inst_d;
   logic [INST_W-1:0]     inst_pc_q, inst_pc_d;
   logic                  inst_valid_q, inst_valid_d;
   logic                  discard_q, discard_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;

   logic                  ready_s;
   logic                  redirect_bad;
   logic                  buf_free;
   logic                  req_done;
   logic [CNT_W-1:0]      cnt_inc;
   logic                  timeout_hit;

   sync2 #(.WIDTH(1)) u_ready_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (mem_ready),
      .q_o   (ready_s)
   );

   // A redirect flushes the buffer, so it also frees the slot for the in-flight word.
   assign redirect_bad = redirect_valid && !is_word_aligned(redirect_pc);
   assign buf_free     = !inst_valid_q || inst_ready || redirect_valid;
   assign req_done     = (state_q == ST_REQ) && ready_s && buf_free;
   assign cnt_inc      = cnt_q + CNT_W'(1);
   assign timeout_hit  = (cnt_inc == TIMEOUT_CNT);

   // NOTE: every register uses <= so all flops update from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         fetch_pc_q   <= RESET_PC;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         inst_valid_q <= 1'b0;
         discard_q    <= 1'b0;
         cnt_q        <= '0;
         mem_addr_q   <= RESET_PC[MEM_ADDR_W-1:0];
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
         discard_q    <= discard_d;
         cnt_q        <= cnt_d;
         mem_addr_q   <= mem_addr_d;
      end
   end

   // cs only moves once ready_s has caught up with it, so the RAM never sees
   // an edge during its response delay.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!ready_s) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (req_done)         state_d = ST_RELEASE;
            else if (timeout_hit) state_d = ST_FAULT;
         end
         ST_RELEASE: begin
            if (!ready_s)         state_d = ST_REQ;
            else if (timeout_hit) state_d = ST_FAULT;
         end
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_FAULT;
      endcase
      if ((state_q != ST_FAULT) && redirect_bad) state_d = ST_FAULT;
   end

   always_comb begin
      mem_cs = 1'b0;
      fault  = 1'b0;
      unique case (state_q)
         ST_REQ:   mem_cs = 1'b1;
         ST_FAULT: fault  = 1'b1;
         default:  ;
      endcase
   end

   // NOTE: every _d gets its hold value first so no path through this block infers a latch.
   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      discard_d    = discard_q;
      inst_valid_d = inst_valid_q && !inst_ready;
      cnt_d        = cnt_q;

      if (state_q != ST_FAULT) begin
         if (req_done) begin
            discard_d = 1'b0;
            if (!discard_q && !redirect_valid) begin
               inst_d       = mem_rdata;
               inst_pc_d    = fetch_pc_q;
               inst_valid_d = 1'b1;
               fetch_pc_d   = fetch_pc_q + 32'd4;
            end
         end
         // Redirect wins over capture; a request still in flight is marked stale.
         if (redirect_valid) begin
            inst_valid_d = 1'b0;
            fetch_pc_d   = redirect_pc;
            if ((state_q == ST_REQ) && !req_done) discard_d = 1'b1;
         end
      end

      if (state_d == ST_FAULT) inst_valid_d = 1'b0;

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if ((state_q == ST_REQ) || (state_q == ST_RELEASE)) begin
         cnt_d = cnt_inc;
      end

      // The RAM address is frozen for the whole request phase, even across a redirect.
      mem_addr_d = (state_q == ST_REQ) ? mem_addr_q : fetch_pc_d[MEM_ADDR_W-1:0];
   end

   assign mem_we         = 1'b0;
   assign mem_data_valid = 1'b0;
   assign mem_wdata      = '0;
   assign mem_addr       = mem_addr_q;
   assign inst_valid     = inst_valid_q;
   assign inst           = inst_q;
   assign inst_pc        = inst_pc_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the instruction-memory RAM: owns the fetch PC, drives the RAM's level-sensitive chip-select request, waits for its asynchronous `data_ready`, and hands each fetched word to decode through a one-entry valid/ready buffer. Handles branch/jump redirects, discards stale in-flight words, and halts with a fault on RAM timeout or a misaligned target.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset (word aligned)
- `TIMEOUT`, 255, max cycles in one RAM phase before fault (8-bit counter)

Ports:
- `clk` in 1, single clock
- `rst_n` in 1, reset, asynchronous, active-low
- `mem_cs` out 1, RAM chip_select (request level)
- `mem_we` out 1, RAM write_enable, constant 0
- `mem_data_valid` out 1, RAM data_valid, constant 0
- `mem_wdata` out 32, RAM data_i, constant 0
- `mem_addr` out 15, RAM byte address = `fetch_pc[14:0]`
- `mem_ready` in 1, RAM data_ready (asynchronous to `clk`)
- `mem_rdata` in 32, RAM data_o
- `redirect_valid` in 1, load new PC this cycle
- `redirect_pc` in 32, redirect target
- `inst_valid` out 1, `inst`/`inst_pc` valid to decode
- `inst_ready` in 1, decode accepts
- `inst` out 32, fetched instruction
- `inst_pc` out 32, PC of `inst`
- `fault` out 1, sticky fault, cleared only by reset

## Operation
- `mem_ready` passes through a 2-flop synchronizer -> `ready_s`; `mem_rdata` is sampled only when `ready_s`=1 (stable ≥2 cycles by then).
- States: IDLE, REQ, RELEASE, FAULT. Reset: IDLE, `fetch_pc`=RESET_PC, all outputs 0, `discard`=0, counter 0.
- IDLE: `ready_s`=0 -> REQ (`mem_cs`<=1).
- REQ: `mem_cs`=1, `mem_addr` held stable. When `ready_s`=1 and buffer free (`!inst_valid || inst_ready`): if `discard` drop word, else load `inst`<=`mem_rdata`, `inst_pc`<=`fetch_pc`, `inst_valid`<=1, `fetch_pc`<=`fetch_pc`+4 (mod 2^32); then `mem_cs`<=0, `discard`<=0 -> RELEASE. Buffer full: stay in REQ, `mem_cs` stays high.
- RELEASE: `mem_cs`=0; `ready_s`=0 -> REQ with `mem_cs`<=1 (prefetch allowed while buffer full).
- `mem_cs` never toggles while `ready_s` differs from `mem_cs`: the RAM ignores edges during its response delay.
- Redirect (any state except FAULT): `inst_valid`<=0, `fetch_pc`<=`redirect_pc`; if in REQ, `discard`<=1 (in-flight word dropped, REQ still completes normally). Redirect beats capture in the same cycle; a handshake `inst_valid&&inst_ready` coinciding with redirect counts as consumed.
- `redirect_pc[1:0]`!=0 -> FAULT.
- Counter clears on every state change, increments in REQ/RELEASE; reaching TIMEOUT -> FAULT.
- FAULT: `mem_cs`<=0, `inst_valid`<=0, `fault`=1, ignores all inputs until reset.
- `mem_addr` wraps naturally at 32 KiB; `fetch_pc` keeps full 32 bits.

## Timing
- Reset mid-transaction: `mem_cs` drops immediately (async); bench RAM must be allowed to settle.
- Request latency: `mem_cs` rise -> `inst_valid` = RAM delay rounded up + 2 sync cycles + 1 capture cycle.
- Back-to-back: next `mem_cs` rise ≥3 cycles after `mem_cs` fall (RAM fall delay + sync + 1).
- `inst`, `inst_pc` stable while `inst_valid`=1 and `inst_ready`=0.
- `fault` rises one cycle after the triggering condition.

## Structure
- Shared package: state encoding enum, `INST_W`=32, `MEM_ADDR_W`=15, `NOP`=32'h0000_0013.
- Sub-module: `sync2` (generic 2-flop synchronizer with async active-low reset), reusable for data memory.

## Test plan
- Reset release, imem words 0x00000013/0x00100093 at 0x0/0x4, `inst_ready`=1 -> `inst`=0x00000013 `inst_pc`=0x0, then 0x00100093 `inst_pc`=0x4, `mem_we`=0 throughout.
- `inst_ready`=0 for 40 cycles -> first word held; `mem_cs` stays high on second request; no PC advance past 0x4 until accept.
- Redirect to 0x100 while REQ at 0x8 in flight -> word from 0x8 never appears; next `inst_pc`=0x100.
- Redirect in same cycle as `ready_s` capture -> captured word discarded, `inst_valid` stays 0.
- `redirect_pc`=0x102 -> `fault`=1 next cycle, `mem_cs`=0, no further requests; only `rst_n` clears.
- RAM `data_ready` tied 0 -> `fault`=1 after 255 cycles in REQ; `fetch_pc` 0x7FFC then +4 -> `mem_addr`=0x0000.
